// File: rtl/alu_pkg.sv
`default_nettype none
// ==========================================================================
// alu_pkg : shared widths, group selects and opcodes for the 4-bit ALU
// Rev 1.0
// ==========================================================================
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 2;
  localparam int CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic GRP_ARITH = 1'b0;
  localparam logic GRP_LOGIC = 1'b1;

  localparam logic [OP_W-1:0] OP_INC = 2'b00;
  localparam logic [OP_W-1:0] OP_NEG = 2'b01;
  localparam logic [OP_W-1:0] OP_ADD = 2'b10;
  localparam logic [OP_W-1:0] OP_SUB = 2'b11;

  localparam logic [OP_W-1:0] OP_AND = 2'b00;
  localparam logic [OP_W-1:0] OP_OR  = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR = 2'b10;
  localparam logic [OP_W-1:0] OP_NOT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ==========================================================================
// alu_core : combinational datapath producing result and Z/C/S flags
// Rev 1.0
// ==========================================================================
module alu_core
  import alu_pkg::*;
(
  input  logic              l,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r,
  output logic              z,
  output logic              c,
  output logic              s
);

  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W:0] sum;

  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    s   = 1'b0;
    if (l == GRP_ARITH) begin
      // Every arithmetic op goes through one 5-bit sum so carry/sign come out uniformly
      case (op)
        OP_INC: sum = {1'b0, a} + ONE;
        OP_NEG: sum = {1'b0, ~b} + ONE;
        OP_ADD: sum = {1'b0, a} + {1'b0, b};
        OP_SUB: sum = {1'b0, a} + {1'b0, ~b} + ONE;
      endcase
      r = sum[DATA_W-1:0];
      c = sum[DATA_W];
      s = sum[DATA_W-1];
    end else begin
      case (op)
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_NOT: r = ~a;
      endcase
    end
  end

  assign z = (r == '0);

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ==========================================================================
// alu_unit : single-entry valid/ready wrapper around alu_core with a
//            saturating consumed-result counter
// Rev 1.0
// ==========================================================================
module alu_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              l,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] r,
  output logic              z,
  output logic              c,
  output logic              s,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              accept, consume;
  logic [DATA_W-1:0] core_r;
  logic              core_z, core_c, core_s;
  logic [DATA_W-1:0] r_q, r_d;
  logic              z_q, z_d, c_q, c_d, s_q, s_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  alu_core u_core (
    .l  (l),
    .op (op),
    .a  (a),
    .b  (b),
    .r  (core_r),
    .z  (core_z),
    .c  (core_c),
    .s  (core_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_FULL;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end
  end

  // Pass-through on consume lets a new request enter while the old one leaves
  always_comb begin
    out_valid = (state_q == ST_FULL);
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    consume   = out_valid && out_ready;
  end

  always_comb begin
    r_d        = r_q;
    z_d        = z_q;
    c_d        = c_q;
    s_d        = s_q;
    done_cnt_d = done_cnt_q;
    if (accept) begin
      r_d = core_r;
      z_d = core_z;
      c_d = core_c;
      s_d = core_s;
    end
    if (consume && (done_cnt_q != CNT_MAX)) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      s_q        <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      r_q        <= r_d;
      z_q        <= z_d;
      c_q        <= c_d;
      s_q        <= s_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign r        = r_q;
  assign z        = z_q;
  assign c        = c_q;
  assign s        = s_q;
  assign done_cnt = done_cnt_q;

endmodule
`default_nettype wire

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter none; operand width fixed at 4 bits, opcode width 2 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 l  input  1  0 = arithmetic group, 1 = logic group.
REQ-007 op  input  2  operation select within group.
REQ-008 a, b  input  4 each  operands.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 r  output  4  result; z, c, s  output  1 each  zero, carry, sign flags.
REQ-012 done_cnt  output  8  count of results consumed, saturating.

Function
REQ-013 Request accepted SHALL mean in_valid && in_ready at a rising edge; response consumed SHALL mean out_valid && out_ready at a rising edge.
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational; single-entry pipeline with pass-through on consume).
REQ-015 Latency SHALL be exactly 1 cycle: result of a request accepted at edge N visible on r/z/c/s with out_valid=1 after edge N.
REQ-016 r, z, c, s SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 Simultaneous consume and accept SHALL load the new result and keep out_valid=1; consume without accept SHALL clear out_valid.
REQ-018 State machine: EMPTY (out_valid=0) -> FULL on accept; FULL -> FULL on accept (with or without consume) or hold; FULL -> EMPTY on consume without accept.
REQ-019 Arithmetic (l=0), computed as 5-bit sum, r = sum[3:0], c = sum[4], s = sum[3]: op00 a+1; op01 {0,~b}+1; op10 a+b; op11 a+{0,~b}+1 (c=1 iff a>=b).
REQ-020 Logic (l=1): op00 a&b; op01 a|b; op10 a^b; op11 ~a; c and s SHALL be 0.
REQ-021 z SHALL be 1 iff r==4'b0000, both groups.
REQ-022 Inputs l, op, a, b SHALL be sampled only on accept; changes at other times SHALL have no effect.
REQ-023 done_cnt SHALL increment by 1 on each consume and hold at 8'hFF.
REQ-024 No X SHALL propagate to outputs for any combination of defined inputs.

Reset
REQ-025 reset_n=0 SHALL immediately force out_valid=0, r=0, z=0, c=0, s=0, done_cnt=0, state EMPTY; in_ready=1 during and after reset.
REQ-026 Reset asserted while FULL SHALL discard the pending result; no consume counted.
REQ-027 First accept SHALL be possible at the first rising edge after reset_n deasserts.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode constants (OP_INC/OP_NEG/OP_ADD/OP_SUB, OP_AND/OP_OR/OP_XOR/OP_NOT), group constants, and data width 4.
REQ-029 Combinational datapath SHALL be one sub-module alu_core (inputs a, b, op, l; outputs r, z, c, s); alu_unit holds handshake, registers and counter.
REQ-030 Target size 120-400 RTL lines total.

Verification
REQ-031 Exhaustive sweep: l in {0,1}, op 0..3, a,b 0..15, out_ready=1 -> each result 1 cycle after accept matches REQ-019..021, zero mismatches over 2048 operations.
REQ-032 l=0 op=11 a=3 b=5 -> r=1110, c=0, s=1, z=0; a=5 b=5 -> r=0000, c=1, z=1.
REQ-033 Backpressure: accept l=0 op=10 a=9 b=8, hold out_ready=0 for 5 cycles -> r=0001, c=1 stable, in_ready=0; then out_ready=1 -> consumed, done_cnt+1.
REQ-034 Back-to-back: in_valid=1, out_ready=1 every cycle for 4 requests -> 4 results on consecutive cycles, out_valid never drops, done_cnt=4.
REQ-035 Reset mid-operation: reset_n=0 while out_valid=1 -> out_valid=0, r=0, done_cnt=0 immediately, before next clock edge.
REQ-036 Saturation: 260 consumes -> done_cnt=8'hFF.
